// File: rtl/present_pkg.sv
// Shared PRESENT cipher primitives: S-box table, bit permutation and FSM state type.
package present_pkg;

  localparam int KEY80  = 80;
  localparam int KEY128 = 128;

  // Element [x] holds S(x); listed from x=15 down to x=0.
  localparam logic [15:0][3:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

  typedef enum logic [1:0] {
    IDLE,
    READY,
    RUN,
    DONE
  } present_fsm_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  // Bit i moves to 16*(i mod 4) + i/4, i.e. the index with its 2-bit and 4-bit fields swapped.
  function automatic logic [63:0] player64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (logic [6:0] i = 7'd0; i < 7'd64; i++) begin
      y[{i[1:0], i[5:2]}] = x[i[5:0]];
    end
    return y;
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Combinational PRESENT key-register update for one round (80- or 128-bit variant).
import present_pkg::*;

module present_key_schedule #(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] rk_i,
  input  logic [4:0]       cnt_i,
  output logic [KEY_W-1:0] rk_o
);

  logic [KEY_W-1:0] rot;

  assign rot = {rk_i[KEY_W-62:0], rk_i[KEY_W-1:KEY_W-61]};

  generate
    if (KEY_W == KEY128) begin : g_k128
      always_comb begin
        rk_o            = rot;
        rk_o[127:124]   = sbox4(rot[127:124]);
        rk_o[123:120]   = sbox4(rot[123:120]);
        rk_o[66:62]     = rot[66:62] ^ cnt_i;
      end
    end else begin : g_k80
      always_comb begin
        rk_o          = rot;
        rk_o[79:76]   = sbox4(rot[79:76]);
        rk_o[19:15]   = rot[19:15] ^ cnt_i;
      end
    end
  endgenerate

endmodule

// File: rtl/present_sub_per.sv
// Combinational PRESENT round body: sixteen parallel 4-bit S-boxes followed by the bit permutation.
import present_pkg::*;

module sub_per (
  input  logic [63:0] state_i,
  output logic [63:0] state_o
);

  logic [63:0] sub;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      assign sub[4*gi +: 4] = sbox4(state_i[4*gi +: 4]);
    end
  endgenerate

  assign state_o = player64(sub);

endmodule

// File: rtl/present_encryptor_param.sv
// PRESENT encryption core, one round per clock, retained master key, valid/ready on all three streams.
import present_pkg::*;

module present_encryptor_param #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [63:0]      data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [63:0]      data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             busy_o
);

  generate
    if (KEY_W != KEY80 && KEY_W != KEY128) begin : g_bad_key_w
      $error("present_encryptor_param: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_encryptor_param: ROUNDS must be in 1..31");
    end
  endgenerate

  localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

  present_fsm_t     state_q, state_d;
  logic [KEY_W-1:0] mkey_q, mkey_d;
  logic [KEY_W-1:0] rk_q, rk_d, rk_next;
  logic [63:0]      st_q, st_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [63:0]      round_key;
  logic [63:0]      sp_out;

  assign round_key = rk_q[KEY_W-1 -: 64];

  sub_per u_sub_per (
    .state_i (st_q ^ round_key),
    .state_o (sp_out)
  );

  present_key_schedule #(
    .KEY_W (KEY_W)
  ) u_key_schedule (
    .rk_i  (rk_q),
    .cnt_i (cnt_q),
    .rk_o  (rk_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mkey_q  <= '0;
      rk_q    <= '0;
      st_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mkey_q  <= mkey_d;
      rk_q    <= rk_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mkey_d       = mkey_q;
    rk_d         = rk_q;
    st_d         = st_q;
    cnt_d        = cnt_q;
    key_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    data_valid_o = 1'b0;
    data_o       = '0;
    busy_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        key_ready_o = 1'b1;
        if (key_valid_i) begin
          mkey_d  = key_i;
          state_d = READY;
        end
      end

      READY: begin
        key_ready_o  = 1'b1;
        data_ready_o = !key_valid_i;
        // A key offer wins over a plaintext offered in the same cycle.
        if (key_valid_i) begin
          mkey_d = key_i;
        end else if (data_valid_i) begin
          st_d    = data_i;
          rk_d    = mkey_q;
          cnt_d   = 5'd1;
          state_d = RUN;
        end
      end

      RUN: begin
        busy_o = 1'b1;
        st_d   = sp_out;
        rk_d   = rk_next;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      DONE: begin
        data_valid_o = 1'b1;
        data_o       = st_q ^ round_key;
        data_ready_o = data_ready_i;
        // Consuming the result while a new block is offered restarts without a bubble.
        if (data_ready_i) begin
          if (data_valid_i) begin
            st_d    = data_i;
            rk_d    = mkey_q;
            cnt_d   = 5'd1;
            state_d = RUN;
          end else begin
            state_d = READY;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_present_encryptor_param.sv
// Self-checking bench: known-answer table, randomized blocks vs. a behavioural PRESENT model, handshake corners.
module tb_present_encryptor_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: KEY_W=80/ROUNDS=31, 1: KEY_W=128/ROUNDS=31, 2: KEY_W=80/ROUNDS=1
  logic [127:0] key_in [3];
  logic         kv     [3];
  logic         dv     [3];
  logic         dri    [3];
  logic [63:0]  din    [3];
  logic         kr     [3];
  logic         dro    [3];
  logic         dvo    [3];
  logic         busy   [3];
  logic [63:0]  dout   [3];

  int checks   = 0;
  int failures = 0;

  present_encryptor_param #(.KEY_W(80), .ROUNDS(31)) dut80 (
    .clk_i(clk), .rst_i(rst), .key_i(key_in[0][79:0]), .key_valid_i(kv[0]), .key_ready_o(kr[0]),
    .data_i(din[0]), .data_valid_i(dv[0]), .data_ready_o(dro[0]), .data_o(dout[0]),
    .data_valid_o(dvo[0]), .data_ready_i(dri[0]), .busy_o(busy[0]));

  present_encryptor_param #(.KEY_W(128), .ROUNDS(31)) dut128 (
    .clk_i(clk), .rst_i(rst), .key_i(key_in[1]), .key_valid_i(kv[1]), .key_ready_o(kr[1]),
    .data_i(din[1]), .data_valid_i(dv[1]), .data_ready_o(dro[1]), .data_o(dout[1]),
    .data_valid_o(dvo[1]), .data_ready_i(dri[1]), .busy_o(busy[1]));

  present_encryptor_param #(.KEY_W(80), .ROUNDS(1)) dut_r1 (
    .clk_i(clk), .rst_i(rst), .key_i(key_in[2][79:0]), .key_valid_i(kv[2]), .key_ready_o(kr[2]),
    .data_i(din[2]), .data_valid_i(dv[2]), .data_ready_o(dro[2]), .data_o(dout[2]),
    .data_valid_o(dvo[2]), .data_ready_i(dri[2]), .busy_o(busy[2]));

  int unsigned sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic int kw_of(input int w);
    return (w == 1) ? 128 : 80;
  endfunction

  function automatic int rounds_of(input int w);
    return (w == 2) ? 1 : 31;
  endfunction

  // Reference PRESENT encryption straight from the cipher definition.
  function automatic logic [63:0] ref_enc(input logic [127:0] key, input logic [63:0] pt,
                                          input int kw, input int rounds);
    logic [127:0] k;
    logic [79:0]  k80;
    logic [63:0]  s;
    logic [63:0]  t;
    k = key;
    s = pt;
    for (int r = 1; r <= rounds + 1; r++) begin
      s = s ^ ((kw == 80) ? k[79:16] : k[127:64]);
      if (r > rounds) break;
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      if (kw == 80) begin
        k80 = k[79:0];
        k80 = (k80 << 61) | (k80 >> 19);
        k80[79:76] = 4'(sb[k80[79:76]]);
        k80[19:15] = k80[19:15] ^ 5'(r);
        k = {48'b0, k80};
      end else begin
        k = (k << 61) | (k >> 67);
        k[127:124] = 4'(sb[k[127:124]]);
        k[123:120] = 4'(sb[k[123:120]]);
        k[66:62]   = k[66:62] ^ 5'(r);
      end
    end
    return s;
  endfunction

  function automatic logic [127:0] rand_key(input int kw);
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (kw == 80) k[127:80] = '0;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input int w, input logic [127:0] k);
    key_in[w] = k;
    kv[w] = 1'b1;
    #1;
    check($sformatf("key_ready_dut%0d", w), 64'(kr[w]), 64'd1);
    tick();
    kv[w] = 1'b0;
  endtask

  task automatic start_block(input int w, input logic [63:0] pt);
    din[w] = pt;
    dv[w] = 1'b1;
    #1;
    check($sformatf("data_ready_dut%0d", w), 64'(dro[w]), 64'd1);
    tick();
    dv[w] = 1'b0;
  endtask

  task automatic wait_done(input int w, input string name, input logic [63:0] exp);
    int n;
    n = 0;
    while (!dvo[w] && n < 100) begin
      tick();
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(rounds_of(w)));
    check(name, dout[w], exp);
    $display("blk %s dut%0d ct=%h exp=%h lat=%0d", name, w, dout[w], exp, n);
  endtask

  task automatic consume(input int w);
    dri[w] = 1'b1;
    tick();
    dri[w] = 1'b0;
  endtask

  typedef struct {
    bit           reload;
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  exp;
  } vec_t;

  vec_t         vecs [4];
  logic [127:0] cur_key;
  logic [63:0]  pt;
  logic [63:0]  held;

  initial begin
    for (int w = 0; w < 3; w++) begin
      key_in[w] = '0;
      kv[w]     = 1'b0;
      dv[w]     = 1'b0;
      dri[w]    = 1'b0;
      din[w]    = '0;
    end

    vecs[0] = '{1'b1, 128'h0, 64'h0, 64'h5579C1387B228445};
    vecs[1] = '{1'b1, {48'b0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'h0, 64'hE72C46C0F5945049};
    vecs[2] = '{1'b0, {48'b0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2};
    vecs[3] = '{1'b1, 128'h0, 64'hFFFFFFFFFFFFFFFF, 64'hA112FFC72F68417B};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("rst_data_o_dut%0d", w), dout[w], 64'h0);
      check($sformatf("rst_valid_dut%0d", w), 64'(dvo[w]), 64'd0);
      check($sformatf("rst_busy_dut%0d", w), 64'(busy[w]), 64'd0);
      check($sformatf("rst_key_ready_dut%0d", w), 64'(kr[w]), 64'd1);
      check($sformatf("rst_data_ready_dut%0d", w), 64'(dro[w]), 64'd0);
    end

    // Known-answer table, including a block without key reload
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].reload) load_key(0, vecs[i].key);
      start_block(0, vecs[i].pt);
      wait_done(0, $sformatf("kat%0d", i), vecs[i].exp);
      consume(0);
    end

    // Randomized blocks, key reloaded only sometimes
    cur_key = '0;
    for (int n = 0; n < 10; n++) begin
      if (n == 0 || $urandom_range(1) == 1) begin
        cur_key = rand_key(80);
        load_key(0, cur_key);
      end
      pt = {$urandom, $urandom};
      start_block(0, pt);
      wait_done(0, $sformatf("rnd%0d", n), ref_enc(cur_key, pt, 80, 31));
      consume(0);
    end

    // Stall in DONE, then same-edge output/input handshake
    load_key(0, 128'h0);
    start_block(0, 64'h0);
    wait_done(0, "stall_first", 64'h5579C1387B228445);
    held = dout[0];
    din[0] = 64'hFFFFFFFFFFFFFFFF;
    dv[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall_data_o_c%0d", c), dout[0], held);
      check($sformatf("stall_data_ready_c%0d", c), 64'(dro[0]), 64'd0);
      tick();
    end
    dri[0] = 1'b1;
    #1;
    check("b2b_data_ready", 64'(dro[0]), 64'd1);
    tick();
    dri[0] = 1'b0;
    dv[0] = 1'b0;
    check("b2b_valid_drop", 64'(dvo[0]), 64'd0);
    check("b2b_busy", 64'(busy[0]), 64'd1);
    wait_done(0, "b2b_second", 64'hA112FFC72F68417B);
    consume(0);

    // Key and plaintext offered together in READY: key wins
    cur_key = rand_key(80);
    pt = {$urandom, $urandom};
    key_in[0] = cur_key;
    kv[0] = 1'b1;
    din[0] = pt;
    dv[0] = 1'b1;
    #1;
    check("prio_data_ready", 64'(dro[0]), 64'd0);
    check("prio_key_ready", 64'(kr[0]), 64'd1);
    tick();
    kv[0] = 1'b0;
    #1;
    check("prio_not_started", 64'(busy[0]), 64'd0);
    check("prio_data_ready_next", 64'(dro[0]), 64'd1);
    tick();
    dv[0] = 1'b0;
    wait_done(0, "prio_newkey", ref_enc(cur_key, pt, 80, 31));
    consume(0);

    // 128-bit key instance
    load_key(1, 128'h0);
    start_block(1, 64'h0);
    wait_done(1, "k128_zero", 64'h96DB702A2E6900AF);
    consume(1);
    for (int n = 0; n < 3; n++) begin
      cur_key = rand_key(128);
      pt = {$urandom, $urandom};
      load_key(1, cur_key);
      start_block(1, pt);
      wait_done(1, $sformatf("k128_rnd%0d", n), ref_enc(cur_key, pt, 128, 31));
      consume(1);
    end

    // Single-round instance
    for (int n = 0; n < 3; n++) begin
      cur_key = rand_key(80);
      pt = {$urandom, $urandom};
      load_key(2, cur_key);
      start_block(2, pt);
      wait_done(2, $sformatf("r1_rnd%0d", n), ref_enc(cur_key, pt, 80, 1));
      consume(2);
    end

    // Reset mid-RUN aborts and drops the key
    cur_key = rand_key(80);
    load_key(0, cur_key);
    start_block(0, {$urandom, $urandom});
    repeat (14) tick();
    check("mid_run_busy", 64'(busy[0]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_data_o", dout[0], 64'h0);
    check("abort_valid", 64'(dvo[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_key_ready", 64'(kr[0]), 64'd1);
    check("abort_data_ready", 64'(dro[0]), 64'd0);
    #1;
    rst = 1'b0;
    din[0] = {$urandom, $urandom};
    dv[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("nokey_data_ready_c%0d", c), 64'(dro[0]), 64'd0);
      check($sformatf("nokey_busy_c%0d", c), 64'(busy[0]), 64'd0);
    end
    dv[0] = 1'b0;
    load_key(0, cur_key);
    pt = {$urandom, $urandom};
    start_block(0, pt);
    wait_done(0, "after_reset", ref_enc(cur_key, pt, 80, 31));
    consume(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
